display_scanner: RTL and testbench
==================================

# display_scanner

Parametrised time-multiplexing scanner for common-anode/cathode 7-segment banks. It selects one digit at a time at a programmable slot rate and skips digits that are masked off. Each slot opens with an anti-ghosting blanking interval. It drives the digit index used by the segment-data mux and the per-digit anode lines, and sits between the display datapath and the board pins.

## Interface
- NUM_DIGITS, 6, number of digits scanned (≥1)
- CLK_DIV, 50000, clk cycles per digit slot (≥2)
- BLANK_CYCLES, 16, cycles at slot start with all anodes off (0 ≤ BLANK_CYCLES < CLK_DIV)
- ANODE_ACTIVE_LOW, 1, 1: active anode driven 0; 0: driven 1
- IW (localparam), max(1,$clog2(NUM_DIGITS)), index width

Ports (reset is asynchronous, active-high; clock is clk):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- enable  in  1  scanning on; low forces all anodes off
- digit_mask  in  NUM_DIGITS  1 = digit participates in scan; sampled only at slot boundaries and on IDLE exit
- digit_sel  out  IW  index of current digit, for segment-data mux
- anode  out  NUM_DIGITS  one-hot digit drive, polarity per ANODE_ACTIVE_LOW
- blank  out  1  1 = segments must be dark (blanking, idle, or no digit enabled)
- scan_tick  out  1  one-cycle pulse in the cycle digit_sel is loaded
- frame_done  out  1  one-cycle pulse with scan_tick when the scan wraps

## Operation
- States: IDLE, BLANK, ON.
- Reset: state=IDLE, digit_sel=0, slot timer=0, anode all inactive, blank=1, scan_tick=0, frame_done=0.
- IDLE:
  - Entered on reset or whenever enable=0, from any state, on the next edge.
  - On entry, anodes go inactive and blank=1; digit_sel holds its value.
- IDLE exit (enable=1):
  - Search digit_mask cyclically from digit_sel inclusive; load the first set index.
  - Assert scan_tick, clear timer, go to BLANK (or ON if BLANK_CYCLES=0).
  - If the mask is all zero, stay in IDLE.
- BLANK: anodes inactive, blank=1. After BLANK_CYCLES cycles, go to ON.
- ON: anode[digit_sel] active, all other anodes inactive, blank=0.
- Slot end (timer reaches CLK_DIV-1):
  - Next index is the first set bit of digit_mask searching cyclically from digit_sel+1.
  - Load it, pulse scan_tick, go to BLANK.
  - frame_done pulses when the new index ≤ the old index (wrap).
  - With a single enabled digit, that digit is reselected every slot and frame_done pulses every slot.
- Mask becomes all zero at a slot boundary: go to IDLE with blank=1; resume via the IDLE exit rule.
- The mask value between boundaries is ignored. A currently lit digit stays lit until slot end even if its bit is cleared.
- Simultaneous enable fall and slot end: enable wins (IDLE), and no scan_tick is issued.
- Reset mid-slot: immediate return to reset values, regardless of clk.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Slot length is exactly CLK_DIV cycles: BLANK_CYCLES blanked cycles, then CLK_DIV−BLANK_CYCLES lit cycles.
- Refresh period = CLK_DIV × (number of enabled digits).
- digit_sel, anode, and blank change on the same edge. Segment data therefore settles during blanking.
- The anode turns on exactly BLANK_CYCLES edges after scan_tick.
- Slot timer width is $clog2(CLK_DIV); it wraps to 0 at slot end.

## Structure
- Package display_pkg holds:
  - state enum scan_state_t {IDLE, BLANK, ON}
  - function anode_onehot(idx, polarity)
- Sub-module next_digit_finder: combinational cyclic priority search.
  - Inputs: mask, start index, inclusive flag.
  - Outputs: index, found, wrapped.
  - Instantiated once.
- Top module holds the FSM, slot timer, and output registers.

## Test plan
All cases use NUM_DIGITS=6, CLK_DIV=8, BLANK_CYCLES=2, ANODE_ACTIVE_LOW=1 unless noted.
- Reset, then enable=1 with mask=6'b111111:
  - digit_sel steps 0,1,2,3,4,5,0 every 8 cycles.
  - anode=6'b111111 for 2 cycles, then 6'b111110, and so on for each digit.
  - frame_done pulses only on the 5→0 step.
- mask=6'b100101: sequence 0,2,5,0; frame_done pulses on the 5→0 step.
- Single enabled digit, mask=6'b001000:
  - digit_sel stays at 3.
  - Blanking recurs every slot; scan_tick and frame_done pulse every 8 cycles.
- mask changed to 0 mid-slot while digit 2 is lit:
  - Digit 2 stays lit to slot end, then IDLE with blank=1 and anode=6'b111111.
  - Restoring mask=6'b000100 resumes at digit 2.
- enable dropped in the same cycle as slot end:
  - Next cycle shows IDLE, no scan_tick, digit_sel unchanged.
- Reset asserted mid-ON with ANODE_ACTIVE_LOW=0:
  - Outputs go asynchronously to anode=0, blank=1, digit_sel=0.
- With BLANK_CYCLES=0: no blanked cycles; the anode is active in the same cycle as scan_tick.

Source files
------------

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and helpers for the 7-segment digit scanner
package display_pkg;

    localparam int MAX_DIGITS = 32;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        ON
    } scan_state_t;

    // One-hot anode pattern for a lit digit; callers truncate to their digit count.
    function automatic logic [MAX_DIGITS-1:0] anode_onehot(input int unsigned idx, input logic active_low);
        logic [MAX_DIGITS-1:0] v;
        v = MAX_DIGITS'(1) << idx;
        return active_low ? ~v : v;
    endfunction

endpackage

// File: rtl/next_digit_finder.sv
// rtl/next_digit_finder.sv - combinational cyclic priority search over the digit mask
module next_digit_finder #(
    parameter int NUM_DIGITS = 6,
    parameter int IW         = 3
) (
    input  logic [NUM_DIGITS-1:0] mask,
    input  logic [IW-1:0]         start,
    input  logic                  inclusive,
    output logic [IW-1:0]         index,
    output logic                  found,
    output logic                  wrapped
);

    always_comb begin
        int s;
        int pos;
        index   = '0;
        found   = 1'b0;
        wrapped = 1'b0;
        s       = int'(start);
        pos     = 0;
        // Walk offsets from farthest to nearest so the nearest set bit wins.
        // Non-inclusive search covers offsets 1..N, so offset N reselects start itself.
        for (int k = NUM_DIGITS; k >= 0; k--) begin
            if ((k != 0 || inclusive) && (k != NUM_DIGITS || !inclusive)) begin
                pos = s + k;
                if (pos >= NUM_DIGITS) begin
                    pos = pos - NUM_DIGITS;
                end
                if (mask[pos]) begin
                    index   = IW'(pos);
                    found   = 1'b1;
                    wrapped = inclusive ? (pos < s) : (pos <= s);
                end
            end
        end
    end

endmodule

// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - time-multiplexed digit scanner with masking and anti-ghost blanking
module display_scanner
    import display_pkg::*;
#(
    parameter int NUM_DIGITS       = 6,
    parameter int CLK_DIV          = 50000,
    parameter int BLANK_CYCLES     = 16,
    parameter int ANODE_ACTIVE_LOW = 1,
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [IW-1:0]         digit_sel,
    output logic [NUM_DIGITS-1:0] anode,
    output logic                  blank,
    output logic                  scan_tick,
    output logic                  frame_done
);

    localparam int TW = $clog2(CLK_DIV);
    localparam logic AL = (ANODE_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{AL}};
    localparam logic [TW-1:0] LAST_SLOT  = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] LAST_BLANK = TW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam scan_state_t SLOT_START = (BLANK_CYCLES == 0) ? ON : BLANK;

    scan_state_t           state, state_n;
    logic [TW-1:0]         timer, timer_n;
    logic [IW-1:0]         sel_n;
    logic [NUM_DIGITS-1:0] anode_n;
    logic                  blank_n, tick_n, frame_n;

    logic [IW-1:0] find_index;
    logic          find_found, find_wrapped;

    // From IDLE the current digit may be reused; at slot end the search starts past it.
    next_digit_finder #(
        .NUM_DIGITS(NUM_DIGITS),
        .IW        (IW)
    ) u_finder (
        .mask     (digit_mask),
        .start    (digit_sel),
        .inclusive(state == IDLE),
        .index    (find_index),
        .found    (find_found),
        .wrapped  (find_wrapped)
    );

    always_comb begin
        state_n = state;
        timer_n = timer;
        sel_n   = digit_sel;
        tick_n  = 1'b0;
        frame_n = 1'b0;
        if (!enable) begin
            state_n = IDLE;
            timer_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (find_found) begin
                        sel_n   = find_index;
                        tick_n  = 1'b1;
                        timer_n = '0;
                        state_n = SLOT_START;
                    end
                end
                BLANK: begin
                    timer_n = timer + TW'(1);
                    if (timer == LAST_BLANK) begin
                        state_n = ON;
                    end
                end
                ON: begin
                    if (timer == LAST_SLOT) begin
                        timer_n = '0;
                        if (find_found) begin
                            sel_n   = find_index;
                            tick_n  = 1'b1;
                            frame_n = find_wrapped;
                            state_n = SLOT_START;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        timer_n = timer + TW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        anode_n = (state_n == ON) ? NUM_DIGITS'(anode_onehot(32'(sel_n), AL)) : ANODE_OFF;
        blank_n = (state_n != ON);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            digit_sel  <= '0;
            anode      <= ANODE_OFF;
            blank      <= 1'b1;
            scan_tick  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            digit_sel  <= sel_n;
            anode      <= anode_n;
            blank      <= blank_n;
            scan_tick  <= tick_n;
            frame_done <= frame_n;
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - self-checking bench for display_scanner against a slot-level model
module tb_display_scanner;

    localparam int N   = 6;
    localparam int DIV = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [5:0] mask = '0;

    logic [2:0] sel0, sel1;
    logic [5:0] an0, an1;
    logic       bl0, bl1, tk0, tk1, fd0, fd1;

    display_scanner #(.NUM_DIGITS(6), .CLK_DIV(8), .BLANK_CYCLES(2), .ANODE_ACTIVE_LOW(1)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .digit_mask(mask),
        .digit_sel(sel0), .anode(an0), .blank(bl0), .scan_tick(tk0), .frame_done(fd0)
    );

    display_scanner #(.NUM_DIGITS(6), .CLK_DIV(8), .BLANK_CYCLES(0), .ANODE_ACTIVE_LOW(0)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .digit_mask(mask),
        .digit_sel(sel1), .anode(an1), .blank(bl1), .scan_tick(tk1), .frame_done(fd1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: per instance, whether scanning, current digit and position within the slot.
    int m_blank[2] = '{2, 0};
    bit m_al[2]    = '{1'b1, 1'b0};
    bit m_act[2];
    int m_sel[2];
    int m_pos[2];
    bit m_tick[2];
    bit m_fd[2];

    function automatic int find(logic [5:0] m, int start, bit incl);
        int lo, hi, j;
        lo = incl ? 0 : 1;
        hi = incl ? N - 1 : N;
        for (int k = lo; k <= hi; k++) begin
            j = (start + k) % N;
            if (m[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_act[i] = 0; m_sel[i] = 0; m_pos[i] = 0; m_tick[i] = 0; m_fd[i] = 0;
            end else begin
                int f;
                m_tick[i] = 0;
                m_fd[i]   = 0;
                if (!enable) begin
                    m_act[i] = 0;
                end else if (!m_act[i]) begin
                    f = find(mask, m_sel[i], 1);
                    if (f >= 0) begin
                        m_sel[i] = f; m_act[i] = 1; m_pos[i] = 0; m_tick[i] = 1;
                    end
                end else if (m_pos[i] == DIV - 1) begin
                    f = find(mask, m_sel[i], 0);
                    if (f < 0) begin
                        m_act[i] = 0;
                    end else begin
                        m_fd[i]  = (f <= m_sel[i]);
                        m_sel[i] = f; m_pos[i] = 0; m_tick[i] = 1;
                    end
                end else begin
                    m_pos[i]++;
                end
            end
        end
    end

    function automatic bit lit(int i);
        return m_act[i] && (m_pos[i] >= m_blank[i]);
    endfunction

    function automatic logic [5:0] exp_anode(int i);
        logic [5:0] oh;
        oh = 6'(1) << m_sel[i];
        if (lit(i)) return m_al[i] ? ~oh : oh;
        return m_al[i] ? 6'h3f : 6'h00;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            chk("sel0",   32'(sel0), 32'(m_sel[0]));
            chk("anode0", 32'(an0),  32'(exp_anode(0)));
            chk("blank0", 32'(bl0),  32'(!lit(0)));
            chk("tick0",  32'(tk0),  32'(m_tick[0]));
            chk("frame0", 32'(fd0),  32'(m_fd[0]));
            chk("sel1",   32'(sel1), 32'(m_sel[1]));
            chk("anode1", 32'(an1),  32'(exp_anode(1)));
            chk("blank1", 32'(bl1),  32'(!lit(1)));
            chk("tick1",  32'(tk1),  32'(m_tick[1]));
            chk("frame1", 32'(fd1),  32'(m_fd[1]));
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    int ticks, fds, nseq;
    int exp_seq[4] = '{0, 2, 5, 0};

    initial begin
        @(negedge clk);
        chk("rst_anode0", 32'(an0), 32'h3f);
        chk("rst_anode1", 32'(an1), 32'h00);
        chk("rst_blank0", 32'(bl0), 32'h1);
        chk("rst_sel0",   32'(sel0), 32'h0);
        chk("rst_tick0",  32'(tk0), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Full mask: 0..5 then wrap, frame_done only on the wrap.
        mask = 6'h3f; enable = 1'b1;
        @(negedge clk);
        chk("p1_tick", 32'(tk0), 32'h1);
        chk("p1_sel",  32'(sel0), 32'h0);
        chk("p1_blanked", 32'(an0), 32'h3f);
        chk("p1_b0_anode", 32'(an1), 32'h01);
        chk("p1_b0_blank", 32'(bl1), 32'h0);
        ticks = 0; fds = 0;
        for (int c = 1; c <= 48; c++) begin
            @(negedge clk);
            if (tk0) ticks++;
            if (fd0) fds++;
            if (c == 2)  chk("p1_lit0", 32'(an0), 32'h3e);
            if (c == 8)  chk("p1_sel1", 32'(sel0), 32'h1);
            if (c == 10) chk("p1_lit1", 32'(an0), 32'h3d);
            if (c == 48) chk("p1_wrap", 32'(fd0), 32'h1);
        end
        chk("p1_ticks", 32'(ticks), 32'd6);
        chk("p1_frames", 32'(fds), 32'd1);

        // Sparse mask 100101.
        enable = 1'b0;
        do_reset();
        mask = 6'b100101; enable = 1'b1;
        nseq = 0; fds = 0;
        for (int c = 0; c <= 24; c++) begin
            @(negedge clk);
            if (tk0) begin
                if (nseq < 4) chk("p2_seq", 32'(sel0), 32'(exp_seq[nseq]));
                nseq++;
            end
            if (fd0) fds++;
        end
        chk("p2_count", 32'(nseq), 32'd4);
        chk("p2_frames", 32'(fds), 32'd1);

        // Single digit reselected every slot.
        enable = 1'b0;
        do_reset();
        mask = 6'b001000; enable = 1'b1;
        @(negedge clk);
        chk("p3_sel", 32'(sel0), 32'h3);
        chk("p3_first_frame", 32'(fd0), 32'h0);
        repeat (8) @(negedge clk);
        chk("p3_tick", 32'(tk0), 32'h1);
        chk("p3_frame", 32'(fd0), 32'h1);
        chk("p3_sel2", 32'(sel0), 32'h3);
        @(negedge clk);
        chk("p3_reblank", 32'(bl0), 32'h1);

        // Mask cleared while digit 2 lit, then restored.
        enable = 1'b0;
        do_reset();
        mask = 6'b000100; enable = 1'b1;
        @(negedge clk);
        chk("p4_sel", 32'(sel0), 32'h2);
        repeat (3) @(negedge clk);
        mask = 6'b000000;
        repeat (4) @(negedge clk);
        chk("p4_still_lit", 32'(an0), 32'h3b);
        @(negedge clk);
        chk("p4_idle_blank", 32'(bl0), 32'h1);
        chk("p4_idle_anode", 32'(an0), 32'h3f);
        chk("p4_idle_tick", 32'(tk0), 32'h0);
        mask = 6'b000100;
        @(negedge clk);
        chk("p4_resume_tick", 32'(tk0), 32'h1);
        chk("p4_resume_sel", 32'(sel0), 32'h2);

        // Enable falls on the slot-end edge.
        enable = 1'b0;
        do_reset();
        mask = 6'h3f; enable = 1'b1;
        @(negedge clk);
        repeat (7) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("p5_no_tick", 32'(tk0), 32'h0);
        chk("p5_sel_hold", 32'(sel0), 32'h0);
        chk("p5_blank", 32'(bl0), 32'h1);

        // Asynchronous reset mid-ON on the active-high, zero-blank instance.
        enable = 1'b1;
        @(negedge clk);
        repeat (9) @(negedge clk);
        chk("p6_pre_sel", 32'(sel1), 32'h1);
        chk("p6_pre_anode", 32'(an1), 32'h02);
        #2 reset = 1'b1;
        #1;
        chk("p6_async_anode", 32'(an1), 32'h00);
        chk("p6_async_blank", 32'(bl1), 32'h1);
        chk("p6_async_sel", 32'(sel1), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Randomized run checked every cycle by the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 999) < 3);
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0: mask = 6'h00;
                    1: mask = 6'(1) << $urandom_range(0, 5);
                    default: mask = 6'($urandom);
                endcase
            end
        end
        reset = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
